// File: rtl/dataflow_pkg.sv
// Shared defaults and helpers for the dataflow serializer blocks.
// Holds the channel-count saturation rule so every block interprets cfg_num_ch identically.
package dataflow_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_NUM_CHANNELS = 4;

    function automatic int idx_width(input int num_ch);
        return ($clog2(num_ch) > 1) ? $clog2(num_ch) : 1;
    endfunction

    // A zero or out-of-range request means "all channels".
    function automatic int eff_num_ch(input int cfg, input int num_ch);
        return (cfg == 0 || cfg > num_ch) ? num_ch : cfg;
    endfunction

endpackage

// File: rtl/serializer_group_buf.sv
// Two-entry group FIFO: stores a packed channel group plus its latched active-channel count.
// Exposes the head entry and the entry behind it so the sequencer can switch groups without a bubble.
module serializer_group_buf #(
    parameter int GROUP_W = 64,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [GROUP_W-1:0] push_data,
    input  logic [CNT_W-1:0]   push_cnt,
    input  logic               pop,
    output logic [1:0]         count,
    output logic [GROUP_W-1:0] head_data,
    output logic [CNT_W-1:0]   head_cnt,
    output logic [GROUP_W-1:0] next_data,
    output logic [CNT_W-1:0]   next_cnt
);

    logic [GROUP_W-1:0] data_mem [2];
    logic [CNT_W-1:0]   cnt_mem  [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push_en;
    logic               pop_en;

    assign push_en = push && (count != 2'd2);
    assign pop_en  = pop && (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_en) wr_ptr <= !wr_ptr;
            if (pop_en)  rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push_en} - {1'b0, pop_en};
        end
    end

    // Payload storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push_en && !clr) begin
            data_mem[wr_ptr] <= push_data;
            cnt_mem[wr_ptr]  <= push_cnt;
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_cnt  = cnt_mem[rd_ptr];
    assign next_data = data_mem[!rd_ptr];
    assign next_cnt  = cnt_mem[!rd_ptr];

endmodule

// File: rtl/channel_serializer.sv
// Serializes packed multi-channel groups into one word per cycle with channel index and last flag.
// All outputs come from registers; the next word is precomputed from the buffer state and handshakes.
module channel_serializer
    import dataflow_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    localparam int IDX_W       = idx_width(NUM_CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic [IDX_W:0]                   cfg_num_ch,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IDX_W-1:0]                 out_ch,
    output logic                             out_last
);

    localparam int CNT_W   = IDX_W + 1;
    localparam int GROUP_W = NUM_CHANNELS * DATA_WIDTH;

    logic [1:0]            count;
    logic [GROUP_W-1:0]    head_data;
    logic [GROUP_W-1:0]    next_data;
    logic [CNT_W-1:0]      head_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [CNT_W-1:0]      push_cnt;
    logic                  push;
    logic                  pop;
    logic                  fire;

    logic                  vld_p1;
    logic                  last_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [IDX_W-1:0]      idx_p1;

    logic [GROUP_W-1:0]    sel_data;
    logic [CNT_W-1:0]      sel_cnt;
    logic [IDX_W-1:0]      idx_n;
    logic [1:0]            count_n;
    logic                  vld_n;
    logic                  last_n;
    logic [DATA_WIDTH-1:0] data_n;

    assign in_ready = (count != 2'd2);
    assign push     = in_valid && in_ready;
    assign fire     = vld_p1 && out_ready;
    assign pop      = fire && last_p1;
    assign push_cnt = CNT_W'(eff_num_ch(int'(cfg_num_ch), NUM_CHANNELS));

    serializer_group_buf #(
        .GROUP_W (GROUP_W),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data (in_data),
        .push_cnt  (push_cnt),
        .pop       (pop),
        .count     (count),
        .head_data (head_data),
        .head_cnt  (head_cnt),
        .next_data (next_data),
        .next_cnt  (next_cnt)
    );

    // Pick the group that will be at the head after this edge, then the word within it.
    always_comb begin
        sel_data = head_data;
        sel_cnt  = head_cnt;
        idx_n    = idx_p1;
        if (pop) begin
            idx_n = '0;
            if (count == 2'd2) begin
                sel_data = next_data;
                sel_cnt  = next_cnt;
            end else begin
                sel_data = in_data;
                sel_cnt  = push_cnt;
            end
        end else begin
            if (fire) idx_n = idx_p1 + IDX_W'(1);
            if (count == 2'd0) begin
                sel_data = in_data;
                sel_cnt  = push_cnt;
            end
        end
        count_n = count + {1'b0, push} - {1'b0, pop};
        vld_n   = (count_n != 2'd0);
        data_n  = '0;
        last_n  = 1'b0;
        if (vld_n) begin
            data_n = sel_data[int'(idx_n)*DATA_WIDTH +: DATA_WIDTH];
            last_n = (CNT_W'(idx_n) == sel_cnt - CNT_W'(1));
        end
    end

    // ---- output register stage (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
            idx_p1  <= '0;
        end else if (clr) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
            idx_p1  <= '0;
        end else begin
            vld_p1  <= vld_n;
            last_p1 <= last_n;
            data_p1 <= data_n;
            idx_p1  <= vld_n ? idx_n : '0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = idx_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_channel_serializer.sv
// Self-checking bench for channel_serializer: a word-queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional flushes.
module tb_channel_serializer;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic [IW:0]       cfg_num_ch;
    logic [NCH*DW-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     out_ch;
    logic              out_last;

    always #5 clk = ~clk;

    channel_serializer #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .cfg_num_ch (cfg_num_ch),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_last   (out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the queue of words still owed to the output, plus groups held.
    typedef struct { logic [DW-1:0] d; int ch; bit last; } word_t;
    typedef struct { logic [DW-1:0] d; int ch; bit last; int cyc; } log_t;
    word_t exp_q[$];
    int    ngroups = 0;
    int    cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        bit    acc;
        bit    con;
        int    n;
        word_t w;
        if (!rst_n) begin
            exp_q.delete();
            ngroups = 0;
        end else begin
            cyc++;
            if (clr) begin
                exp_q.delete();
                ngroups = 0;
            end else begin
                acc = in_valid && (ngroups < 2);
                con = (ngroups > 0) && out_ready;
                if (con) begin
                    if (exp_q[0].last) ngroups--;
                    void'(exp_q.pop_front());
                end
                if (acc) begin
                    n = int'(cfg_num_ch);
                    if (n == 0 || n > NCH) n = NCH;
                    for (int k = 0; k < n; k++) begin
                        w.d    = in_data[k*DW +: DW];
                        w.ch   = k;
                        w.last = (k == n - 1);
                        exp_q.push_back(w);
                    end
                    ngroups++;
                end
            end
        end
    end

    log_t lg[$];
    bit   ir_low_seen = 1'b0;

    always @(negedge clk) begin
        log_t e;
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(ngroups > 0));
            chk("in_ready", int'(in_ready), int'(ngroups < 2));
            if (ngroups > 0) begin
                chk("out_data", int'(out_data), int'(exp_q[0].d));
                chk("out_ch", int'(out_ch), exp_q[0].ch);
                chk("out_last", int'(out_last), int'(exp_q[0].last));
            end
            if (!in_ready) ir_low_seen = 1'b1;
            if (out_valid && out_ready) begin
                e.d    = out_data;
                e.ch   = int'(out_ch);
                e.last = out_last;
                e.cyc  = cyc;
                lg.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_group(input logic [NCH*DW-1:0] d, input int cfg);
        in_data    = d;
        cfg_num_ch = (IW+1)'(cfg);
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic wait_ch2();
        int n;
        n = 0;
        while (!(out_valid && out_ch == 2'd2) && n < 20) begin
            step();
            n++;
        end
        chk("wait_ch2_timeout", int'(n < 20), 1);
    endtask

    localparam logic [NCH*DW-1:0] G1 = 64'hDDD4_CCC3_BBB2_AAA1;
    localparam logic [NCH*DW-1:0] G2 = 64'h4444_3333_2222_1111;
    localparam logic [NCH*DW-1:0] G3 = 64'h9999_8888_7777_6666;

    initial begin
        logic [DW-1:0] t1w [4];
        int            exp_ch [6];
        int            exp_last [6];
        int            t0;
        int            gaps;
        t1w      = '{16'hAAA1, 16'hBBB2, 16'hCCC3, 16'hDDD4};
        exp_ch   = '{0, 1, 0, 1, 2, 3};
        exp_last = '{0, 1, 0, 0, 0, 1};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_num_ch = 3'd4; in_data = '0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_last", int'(out_last), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rst_in_ready", int'(in_ready), 1);

        // Single 4-channel group streamed at full rate
        lg.delete();
        t0 = cyc;
        push_group(G1, 4);
        idle(6);
        chk("t1_words", lg.size(), 4);
        for (int i = 0; i < 4 && i < lg.size(); i++) begin
            chk("t1_data", int'(lg[i].d), int'(t1w[i]));
            chk("t1_ch", lg[i].ch, i);
            chk("t1_last", int'(lg[i].last), int'(i == 3));
            chk("t1_cycle", lg[i].cyc, t0 + 1 + i);
        end

        // Three groups pushed in step with the pops: no output gap, in_ready stays high
        lg.delete();
        ir_low_seen = 1'b0;
        t0 = cyc;
        for (int g = 0; g < 3; g++) begin
            push_group(g == 1 ? G2 : G1, 4);
            idle(3);
        end
        idle(3);
        chk("t2_words", lg.size(), 12);
        gaps = 0;
        for (int i = 0; i < lg.size(); i++) if (lg[i].cyc != t0 + 1 + i) gaps++;
        chk("t2_gaps", gaps, 0);
        chk("t2_in_ready_drop", int'(ir_low_seen), 0);

        // Stall mid-group with both entries full
        lg.delete();
        in_data = G1; cfg_num_ch = 3'd4; in_valid = 1'b1;
        step();
        in_data = G2;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_in_ready", int'(in_ready), 0);
            chk("t3_hold_ch", int'(out_ch), 1);
            chk("t3_hold_data", int'(out_data), 16'hBBB2);
            chk("t3_hold_valid", int'(out_valid), 1);
            step();
        end
        out_ready = 1'b1;
        idle(10);
        chk("t3_words", lg.size(), 8);
        if (lg.size() == 8) begin
            chk("t3_first", int'(lg[0].d), 16'hAAA1);
            chk("t3_second", int'(lg[1].d), 16'hBBB2);
            chk("t3_g2_first", int'(lg[4].d), 16'h1111);
            chk("t3_g2_last", int'(lg[7].d), 16'h4444);
        end

        // cfg=2 then cfg=0 (treated as all channels)
        lg.delete();
        in_data = G1; cfg_num_ch = 3'd2; in_valid = 1'b1;
        step();
        in_data = G2; cfg_num_ch = 3'd0;
        step();
        in_valid = 1'b0;
        idle(8);
        chk("t4_words", lg.size(), 6);
        for (int i = 0; i < 6 && i < lg.size(); i++) begin
            chk("t4_ch", lg[i].ch, exp_ch[i]);
            chk("t4_last", int'(lg[i].last), exp_last[i]);
        end

        // Single-channel groups with in_valid held: one group per cycle
        lg.delete();
        ir_low_seen = 1'b0;
        t0 = cyc;
        cfg_num_ch = 3'd1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'(16'h5000 + i);
            step();
        end
        in_valid = 1'b0;
        idle(3);
        chk("t5_words", lg.size(), 8);
        gaps = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i].cyc != t0 + 1 + i || !lg[i].last || lg[i].ch != 0) gaps++;
        chk("t5_bad_words", gaps, 0);
        chk("t5_in_ready_drop", int'(ir_low_seen), 0);

        // Flush at channel 2 with a second group queued
        cfg_num_ch = 3'd4; in_data = G1; in_valid = 1'b1;
        step();
        in_data = G2;
        step();
        in_valid = 1'b0;
        wait_ch2();
        clr = 1'b1; in_valid = 1'b1; in_data = G3;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_out_valid", int'(out_valid), 0);
        chk("clr_in_ready", int'(in_ready), 1);
        lg.delete();
        push_group(G3, 4);
        idle(6);
        chk("clr_words", lg.size(), 4);
        if (lg.size() > 0) begin
            chk("clr_first_ch", lg[0].ch, 0);
            chk("clr_first_data", int'(lg[0].d), 16'h6666);
        end

        // Asynchronous reset at channel 2
        in_data = G1; in_valid = 1'b1;
        step();
        in_data = G2;
        step();
        in_valid = 1'b0;
        wait_ch2();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_ch", int'(out_ch), 0);
        chk("arst_out_last", int'(out_last), 0);
        idle(2);
        rst_n = 1'b1;
        step();
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_idle_valid", int'(out_valid), 0);
        lg.delete();
        push_group(G2, 4);
        idle(6);
        chk("arst_words", lg.size(), 4);
        if (lg.size() > 0) begin
            chk("arst_first_ch", lg[0].ch, 0);
            chk("arst_first_data", int'(lg[0].d), 16'h1111);
        end

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 99) < 60);
            out_ready  = ($urandom_range(0, 99) < 70);
            cfg_num_ch = (IW+1)'($urandom_range(0, 7));
            in_data    = {$urandom, $urandom};
            clr        = ($urandom_range(0, 63) == 0);
            step();
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(20);
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_in_ready", int'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
